// File: rtl/share_gen_pkg.sv
// Shared types and sizing helpers for the streaming share generator.
// Optional debug unmask port: SHARE_GEN_DEBUG_UNMASK_EN.
package share_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    EMIT
  } state_t;

  function automatic int nbeats(
    input int d,
    input int w,
    input int rnd_w
  );
    return (d * w + rnd_w - 1) / rnd_w;
  endfunction

endpackage

// File: rtl/share_generator_stream_rnd_collector.sv
// Entropy beat counter and mask register for the share generator.
// Last beat keeps only the bits that fit inside the mask width.
module rnd_collector
  import share_gen_pkg::*;
#(
  parameter int M     = 10,
  parameter int RND_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [RND_W-1:0] rnd_in,
  output logic             done,
  output logic [M-1:0]     mask_next
);

  localparam int NB    = nbeats(1, M, RND_W);
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int EXT   = NB * RND_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  logic [CNT_W-1:0] cnt;
  logic [M-1:0]     mask;
  logic [EXT-1:0]   ext;

  // widen to whole beats, drop overflow bits
  always_comb begin
    ext = '0;
    ext[M-1:0] = mask;
    ext[cnt*RND_W +: RND_W] = rnd_in;
  end

  assign mask_next = ext[M-1:0];
  assign done      = we && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt  <= '0;
      mask <= '0;
    end else if (we) begin
      cnt  <= done ? '0 : cnt + 1'b1;
      mask <= mask_next;
    end
  end

endmodule

// File: rtl/share_generator_stream.sv
// Streaming Boolean share generator: one word in, d+1 shares out.
// Optional debug unmask port: SHARE_GEN_DEBUG_UNMASK_EN.
module share_generator_stream
  import share_gen_pkg::*;
#(
  parameter int d        = 2,
  parameter int COL_SIZE = 5,
  parameter int PAR      = 1,
  parameter int RND_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COL_SIZE*PAR-1:0]  data_in,
  input  logic                     rnd_valid,
  output logic                     rnd_ready,
  input  logic [RND_W-1:0]         rnd_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(d+1)*COL_SIZE*PAR-1:0] shares_out,
  output logic                     busy
`ifdef SHARE_GEN_DEBUG_UNMASK_EN
  ,
  output logic [COL_SIZE*PAR-1:0]  dbg_data_out
`endif
);

  localparam int W = COL_SIZE * PAR;
  localparam int M = d * W;

  state_t             state;
  logic [W-1:0]       data;
  logic [W-1:0]       acc;
  logic [M-1:0]       mask_next;
  logic [(d+1)*W-1:0] sh_next;
  logic               done;
  logic               we;
  logic               clr;
  logic               accept;
  logic               release_out;

  assign release_out = (state == EMIT) && out_ready;
  assign in_ready    = rst_n && ((state == IDLE) || release_out);
  assign accept      = in_ready && in_valid;
  assign rnd_ready   = rst_n && (state == GATHER);
  assign out_valid   = rst_n && (state == EMIT);
  assign busy        = rst_n && (state != IDLE);
  assign we          = (state == GATHER) && rnd_valid;
  assign clr         = accept || release_out;

  rnd_collector #(
    .M     (M),
    .RND_W (RND_W)
  ) u_col (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .we        (we),
    .rnd_in    (rnd_in),
    .done      (done),
    .mask_next (mask_next)
  );

  // share0 uses mask_next so the final beat lands this cycle
  always_comb begin
    sh_next = '0;
    acc     = data;
    for (int i = 0; i < d; i++) begin
      sh_next[(i+1)*W +: W] = mask_next[i*W +: W];
      acc = acc ^ mask_next[i*W +: W];
    end
    sh_next[W-1:0] = acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      data       <= '0;
      shares_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= data_in;
            state <= GATHER;
          end
        end
        GATHER: begin
          if (done) begin
            shares_out <= sh_next;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (in_valid) begin
              data  <= data_in;
              state <= GATHER;
            end else begin
              data       <= '0;
              shares_out <= '0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHARE_GEN_DEBUG_UNMASK_EN
  always_comb begin
    dbg_data_out = '0;
    for (int i = 0; i <= d; i++)
      dbg_data_out = dbg_data_out ^ shares_out[i*W +: W];
  end

  a_unmask: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> dbg_data_out == data);
`endif

endmodule

// File: tb/tb_share_generator_stream.sv
// Bench for share_generator_stream: directed cases plus random traffic.
// Reference model rebuilds each mask from the raw consumed beat stream.
module tb_share_generator_stream;

  localparam int D   = 2;
  localparam int W   = 5;
  localparam int RW  = 4;
  localparam int SW  = (D + 1) * W;
  localparam int NBT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_in;
  logic          rnd_valid;
  logic          rnd_ready;
  logic [RW-1:0] rnd_in;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] shares_out;
  logic          busy;
`ifdef SHARE_GEN_DEBUG_UNMASK_EN
  logic [W-1:0]  dbg;
`endif

  int checks = 0;
  int fails  = 0;
  int nout   = 0;
  int beats_total = 0;

  logic [W-1:0]  dq[$];
  logic [RW-1:0] rq[$];
  logic          hold = 1'b0;
  logic [SW-1:0] hsh;

  share_generator_stream #(
    .d(D), .COL_SIZE(W), .PAR(1), .RND_W(RW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .rnd_in     (rnd_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .shares_out (shares_out),
    .busy       (busy)
`ifdef SHARE_GEN_DEBUG_UNMASK_EN
    ,
    .dbg_data_out (dbg)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes are judged on the values held at negedge
  always @(negedge clk) begin
    logic [11:0]  cat;
    logic [9:0]   m;
    logic [W-1:0] dv;
    logic [SW-1:0] exp;
    if (!rst_n) begin
      beats_total -= rq.size();
      dq.delete();
      rq.delete();
      hold = 1'b0;
    end else begin
      if (hold) chk("hold", 32'(shares_out), 32'(hsh));
      if (out_valid) chk("rnd_idle", 32'(rnd_ready), 0);
      if (in_valid && in_ready) dq.push_back(data_in);
      if (rnd_valid && rnd_ready) begin
        rq.push_back(rnd_in);
        beats_total++;
      end
      if (out_valid && out_ready) begin
        chk("have_data", 32'(dq.size() > 0), 1);
        chk("have_beats", 32'(rq.size() >= NBT), 1);
        if (dq.size() > 0 && rq.size() >= NBT) begin
          dv  = dq.pop_front();
          cat = {rq[2], rq[1], rq[0]};
          void'(rq.pop_front());
          void'(rq.pop_front());
          void'(rq.pop_front());
          m   = cat[9:0];
          exp = {m[9:5], m[4:0], dv ^ m[9:5] ^ m[4:0]};
          chk("shares", 32'(shares_out), 32'(exp));
          chk("recomb", 32'(shares_out[14:10] ^ shares_out[9:5]
                            ^ shares_out[4:0]), 32'(dv));
        end
        nout++;
      end
      hold = out_valid && !out_ready;
      hsh  = shares_out;
    end
  end

  initial begin
    int target;
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0;
    rnd_valid = 1'b0; rnd_in = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_rnd_ready", 32'(rnd_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_shares", 32'(shares_out), 0);
    rst_n = 1'b1; #1;
    chk("rel_in_ready", 32'(in_ready), 1);

    // basic split
    in_valid = 1'b1; data_in = 5'h15; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; rnd_valid = 1'b1; rnd_in = 4'hA; #1;
    chk("basic_busy", 32'(busy), 1);
    chk("basic_rnd_ready", 32'(rnd_ready), 1);
    tick(); rnd_in = 4'h5;
    tick(); rnd_in = 4'h1; #1;
    chk("basic_early", 32'(out_valid), 0);
    tick(); rnd_valid = 1'b0; #1;
    chk("basic_ov", 32'(out_valid), 1);
    chk("basic_sh", 32'(shares_out), 32'({5'h0A, 5'h1A, 5'h05}));
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_zero", 32'(shares_out), 0);

    // entropy stall, then output backpressure
    in_valid = 1'b1; data_in = 5'h15; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; rnd_valid = 1'b1; rnd_in = 4'hA;
    tick(); rnd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rr", 32'(rnd_ready), 1);
      chk("stall_ov", 32'(out_valid), 0);
      tick();
    end
    rnd_valid = 1'b1; rnd_in = 4'h5;
    tick(); rnd_in = 4'h1;
    tick(); rnd_in = 4'hF;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ov", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_rnd_ready", 32'(rnd_ready), 0);
      chk("bp_sh", 32'(shares_out), 32'({5'h0A, 5'h1A, 5'h05}));
      tick();
    end

    // back-to-back handoff
    in_valid = 1'b1; data_in = 5'h1F; out_ready = 1'b1; #1;
    chk("b2b_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; rnd_in = 4'h3;
    tick(); rnd_in = 4'hC;
    tick(); rnd_in = 4'h2;
    tick(); rnd_valid = 1'b0; #1;
    chk("b2b_ov", 32'(out_valid), 1);
    chk("b2b_sh", 32'(shares_out), 32'({5'h16, 5'h03, 5'h0A}));
    tick();

    // reset in the middle of gathering
    in_valid = 1'b1; data_in = 5'h0B;
    tick();
    in_valid = 1'b0; rnd_valid = 1'b1; rnd_in = 4'h7;
    tick();
    rnd_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("mr_in_ready", 32'(in_ready), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_rnd_ready", 32'(rnd_ready), 0);
    chk("mr_ov", 32'(out_valid), 0);
    chk("mr_sh", 32'(shares_out), 0);
    rst_n = 1'b1; #1;
    chk("mr_rel", 32'(in_ready), 1);
    in_valid = 1'b1; data_in = 5'h0B;
    tick();
    in_valid = 1'b0; rnd_valid = 1'b1; rnd_in = 4'h9;
    tick(); rnd_in = 4'h6;
    tick(); rnd_in = 4'hE; #1;
    chk("mr_early", 32'(out_valid), 0);
    tick(); rnd_valid = 1'b0; #1;
    chk("mr_sh2", 32'(shares_out), 32'({5'h13, 5'h09, 5'h11}));
    tick();

    // random regression
    target = nout + 1000;
    cyc = 0;
    while (nout < target && cyc < 40000) begin
      in_valid  = 1'($urandom_range(0, 1));
      data_in   = 5'($urandom_range(0, 31));
      rnd_valid = ($urandom_range(0, 3) != 0);
      rnd_in    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0; rnd_valid = 1'b1; out_ready = 1'b1;
    repeat (8) tick();
    rnd_valid = 1'b0;
    tick();
    chk("rand_done", 32'(nout >= target), 1);
    chk("beat_total", 32'(beats_total), 32'(NBT * nout));
    chk("pending", 32'(rq.size() + dq.size()), 0);
    chk("end_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
